baz_share_arbiter: RTL and testbench
====================================

// Module: baz_share_arbiter
//
// PURPOSE
// - Shares one externally defined, fixed-latency Baz-class unit between N requesters.
// - Round-robin arbitration picks one requester per cycle and registers its operand into the unit.
// - A tag pipeline tracks which requester owns each in-flight operation and steers the unit result back to that owner.
// - Sits in the parent level (Foo-class) between the Bar-class clients and the shared Baz instance.
//
// PARAMETERS
// - N    4  number of requesters, >=2
// - W    8  operand/result width
// - LAT  3  Baz latency in cycles, >=1: res_O is valid LAT cycles after res_valid
//
// PORTS
// - CLK         in   1      clock, all state on rising edge
// - RESET       in   1      synchronous active-high reset
// - req_valid   in   N      per-requester operand valid
// - req_data    in   N*W    operands, requester i at [i*W +: W]
// - req_ready   out  N      one-hot or zero; high for the granted requester this cycle
// - res_I       out  W      operand to shared Baz (registered)
// - res_valid   out  1      res_I holds a live operation (registered)
// - res_O       in   W      Baz result, aligned LAT cycles after res_valid
// - rsp_valid   out  N      one-hot or zero; result for requester i is on rsp_data
// - rsp_data    out  W      result data, registered
// - inflight    out  $clog2(LAT+2)  operations issued but not yet returned
//
// BEHAVIOUR
// - Reset values: rr_ptr=0, res_I=0, res_valid=0, all tags invalid, rsp_valid=0, rsp_data=0, inflight=0.
// - Grant (combinational): g = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ..., wrapping mod N.
// - req_ready[g]=1 only when some req_valid is set; otherwise req_ready=0.
// - req_ready does not depend on res_O. There is no issue backpressure; Baz accepts one operation per cycle.
// - Handshake: a transfer occurs when req_valid[i] & req_ready[i]. Requesters hold data until the transfer.
// - After a transfer: rr_ptr <= (g+1) mod N. With no transfer, rr_ptr holds.
// - Issue (1 cycle): res_I <= req_data[g], res_valid <= 1.
// - Idle cycle: res_valid <= 0 and res_I holds its previous value.
// - Tag pipe: LAT+1 stages of {valid, idx}; stage 0 loads {transfer, g}; it shifts every cycle.
//   - Stage k aligns with res_valid delayed by k cycles.
// - Return: when the tag aligned with res_O is valid, on the next edge rsp_valid <= onehot(idx) and rsp_data <= res_O.
//   - Otherwise rsp_valid <= 0 and rsp_data holds.
// - End-to-end latency: transfer at cycle t gives res_valid at t+1 and rsp_valid at t+LAT+2.
// - Responses have no backpressure; requesters must accept rsp_valid in any cycle.
// - inflight: +1 on a transfer, -1 on an rsp_valid pulse, both in the same cycle gives no change.
//   - Maximum value is LAT+1 and it never wraps.
// - Single requester continuously valid: granted every cycle, for full throughput.
// - All N continuously valid: grants rotate rr_ptr, rr_ptr+1, ...; no requester waits more than N-1 cycles.
// - RESET mid-operation: in-flight operations are discarded.
//   - No rsp_valid pulse appears for any operation issued before reset, even though Baz may still output them.
// - RESET overrides any simultaneous transfer; req_ready=0 while RESET=1.
//
// STRUCTURE
// - Package baz_share_pkg:
//   - tag_t struct {logic valid; logic [$clog2(N)-1:0] idx}
//   - rr_pick function (req, ptr -> idx, any)
//   - localparam IDXW
// - Sub-module baz_share_tag_pipe (params DEPTH, IDXW): the shift register of tag_t with synchronous clear.
// - Top level holds the arbiter, the issue registers, the return registers and the inflight counter.
//
// TESTING (N=4, W=8, LAT=3)
// - Reset: assert RESET 2 cycles with req_valid=4'hF -> req_ready=0, res_valid=0, rsp_valid=0, inflight=0.
// - Single op: req_valid[2]=1, data 8'hA5 at cycle t, Baz model returns ~I.
//   - Expect res_I=8'hA5 at t+1 and rsp_valid=4'b0100 with rsp_data=8'h5A at t+5.
// - Round-robin: req_valid=4'hF held for 8 cycles from reset.
//   - Grants 0,1,2,3,0,1,2,3; each requester gets its own result, in order, 5 cycles after its grant.
// - Pointer skip: rr_ptr=1, req_valid=4'b1001 -> grant 3, then rr_ptr=0 -> grant 0.
// - Back-to-back: req_valid=4'b0001 for 6 cycles -> six rsp_valid[0] pulses on consecutive cycles; inflight peaks at 4.
// - Reset mid-flight: issue 3 ops, then pulse RESET 1 cycle after the last issue -> no rsp_valid ever appears, inflight=0.

Source files
------------

// File: rtl/baz_share_pkg.sv
// Shared types and the round-robin pick function for the Baz share arbiter.
package baz_share_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDXW    = $clog2(NUM_REQ);

    typedef struct packed {
        logic            valid;
        logic [IDXW-1:0] idx;
    } tag_t;

    typedef struct packed {
        logic            any;
        logic [IDXW-1:0] idx;
    } pick_t;

    // First set request scanning from ptr upward, wrapping modulo NUM_REQ.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req, input logic [IDXW-1:0] ptr);
        pick_t           p;
        int unsigned     i;
        logic [IDXW-1:0] ii;
        p.any = 1'b0;
        p.idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            i  = (32'(ptr) + k) % NUM_REQ;
            ii = IDXW'(i);
            if (!p.any && req[ii]) begin
                p.any = 1'b1;
                p.idx = ii;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/baz_share_tag_pipe.sv
// Shift register of {valid, idx} tags tracking ownership of in-flight Baz operations.
module baz_share_tag_pipe #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDXW  = 2
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [IDXW:0]   tag_in,
    output logic [IDXW:0]   tag_out
);

    logic [IDXW:0] stage_q [DEPTH];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/baz_share_arbiter.sv
// Round-robin share of one fixed-latency Baz unit between N requesters,
// with a tag pipe steering each result back to its owner.
module baz_share_arbiter
    import baz_share_pkg::*;
#(
    parameter int unsigned N   = NUM_REQ,
    parameter int unsigned W   = 8,
    parameter int unsigned LAT = 3
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [N-1:0]             req_valid,
    input  logic [N*W-1:0]           req_data,
    output logic [N-1:0]             req_ready,
    output logic [W-1:0]             res_I,
    output logic                     res_valid,
    input  logic [W-1:0]             res_O,
    output logic [N-1:0]             rsp_valid,
    output logic [W-1:0]             rsp_data,
    output logic [$clog2(LAT+2)-1:0] inflight
);

    localparam int unsigned CW = $clog2(LAT+2);

    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0]    res_data_q;
    logic            res_valid_q;
    logic [N-1:0]    rsp_valid_q;
    logic [W-1:0]    rsp_data_q;
    logic [CW-1:0]   inflight_q, inflight_d;

    pick_t           pick;
    logic            transfer;
    logic [W-1:0]    op_sel;
    logic [N-1:0]    rsp_oh;
    tag_t            issue_tag;
    tag_t            ret_tag;
    logic [IDXW:0]   ret_tag_bits;

    assign pick     = rr_pick(req_valid, rr_ptr_q);
    // Reset masks the grant so nothing is accepted while clearing.
    assign transfer = pick.any & ~RESET;

    always_comb begin
        req_ready = '0;
        op_sel    = '0;
        rr_ptr_d  = rr_ptr_q;
        for (int unsigned i = 0; i < N; i++) begin
            if (pick.idx == IDXW'(i)) begin
                op_sel = req_data[i*W +: W];
            end
        end
        if (transfer) begin
            req_ready[pick.idx] = 1'b1;
            rr_ptr_d = (pick.idx == IDXW'(N-1)) ? '0 : pick.idx + 1'b1;
        end
    end

    assign issue_tag.valid = transfer;
    assign issue_tag.idx   = pick.idx;

    // Stage LAT lines up with res_O, which arrives LAT cycles after res_valid.
    baz_share_tag_pipe #(
        .DEPTH (LAT + 1),
        .IDXW  (IDXW)
    ) u_tag_pipe (
        .CLK     (CLK),
        .RESET   (RESET),
        .tag_in  (issue_tag),
        .tag_out (ret_tag_bits)
    );

    assign ret_tag = tag_t'(ret_tag_bits);

    always_comb begin
        rsp_oh              = '0;
        rsp_oh[ret_tag.idx] = 1'b1;
        inflight_d          = inflight_q;
        if (transfer && !ret_tag.valid) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!transfer && ret_tag.valid) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rr_ptr_q    <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            inflight_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            res_valid_q <= transfer;
            if (transfer) begin
                res_data_q <= op_sel;
            end
            if (ret_tag.valid) begin
                rsp_valid_q <= rsp_oh;
                rsp_data_q  <= res_O;
            end else begin
                rsp_valid_q <= '0;
            end
            inflight_q <= inflight_d;
        end
    end

    assign res_I     = res_data_q;
    assign res_valid = res_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign inflight  = inflight_q;

endmodule

// File: tb/tb_baz_share_arbiter.sv
// Randomized and directed checks of baz_share_arbiter against a queue-based response model.
module tb_baz_share_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int LAT = 3;
    localparam int CW  = $clog2(LAT+2);

    logic           CLK;
    logic           RESET;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   res_I;
    logic           res_valid;
    logic [W-1:0]   res_O;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic [CW-1:0]  inflight;

    baz_share_arbiter #(
        .N   (N),
        .W   (W),
        .LAT (LAT)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_I     (res_I),
        .res_valid (res_valid),
        .res_O     (res_O),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .inflight  (inflight)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Baz stand-in: returns the bitwise inverse of its operand LAT cycles later.
    logic [W-1:0] baz_q [LAT];
    always @(posedge CLK) begin
        baz_q[0] <= res_I;
        for (int k = 1; k < LAT; k++) baz_q[k] <= baz_q[k-1];
    end
    assign res_O = ~baz_q[LAT-1];

    typedef struct {
        int           due;
        int           idx;
        logic [W-1:0] data;
    } rsp_t;

    rsp_t         exp_q[$];
    int           cyc;
    int           m_ptr;
    int           m_inflight;
    int           m_g;
    logic         m_xfer;
    logic [W-1:0] m_res_I;
    logic         m_res_valid;
    logic [N-1:0] m_rsp_valid;
    logic [W-1:0] m_rsp_data;
    logic [N-1:0] exp_ready;
    logic [N-1:0] act_ready;
    int           n_vec;
    int           n_err;

    // Advance one cycle: sample the grant mid-cycle, then update the model after the edge.
    task automatic tick();
        logic any;
        int   g;
        int   i;
        #2;
        act_ready = req_ready;
        any = 1'b0;
        g   = 0;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (!any && req_valid[i]) begin
                any = 1'b1;
                g   = i;
            end
        end
        m_xfer    = any && !RESET;
        m_g       = g;
        exp_ready = m_xfer ? N'(1 << g) : '0;
        @(posedge CLK);
        #1;
        cyc++;
        if (RESET) begin
            exp_q.delete();
            m_ptr       = 0;
            m_inflight  = 0;
            m_res_I     = '0;
            m_res_valid = 1'b0;
            m_rsp_valid = '0;
            m_rsp_data  = '0;
        end else begin
            if (m_xfer) begin
                m_res_I     = req_data[g*W +: W];
                m_res_valid = 1'b1;
                exp_q.push_back('{due: cyc - 1 + LAT + 2, idx: g, data: ~req_data[g*W +: W]});
                m_ptr = (g + 1) % N;
                m_inflight++;
            end else begin
                m_res_valid = 1'b0;
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                m_rsp_valid = N'(1 << exp_q[0].idx);
                m_rsp_data  = exp_q[0].data;
                void'(exp_q.pop_front());
                m_inflight--;
            end else begin
                m_rsp_valid = '0;
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        RESET = 1'b1;
        repeat (cycles) tick();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = '1;
        req_data  = $urandom();
        RESET     = 1'b1;
        tick();
        tick();
        n_vec++;
        if (act_ready !== '0) begin
            n_err++; $display("FAIL reset_ready got=%b exp=0000", act_ready);
        end
        n_vec++;
        if (res_valid !== 1'b0 || res_I !== '0) begin
            n_err++; $display("FAIL reset_res got=%b/%h exp=0/00", res_valid, res_I);
        end
        n_vec++;
        if (rsp_valid !== '0 || rsp_data !== '0) begin
            n_err++; $display("FAIL reset_rsp got=%b/%h exp=0000/00", rsp_valid, rsp_data);
        end
        n_vec++;
        if (inflight !== '0) begin
            n_err++; $display("FAIL reset_inflight got=%0d exp=0", inflight);
        end
        RESET     = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        req_data  = '0;
        req_data[2*W +: W] = 8'hA5;
        tick();
        n_vec++;
        if (act_ready !== 4'b0100) begin
            n_err++; $display("FAIL single_ready got=%b exp=0100", act_ready);
        end
        req_valid = '0;
        n_vec++;
        if (res_valid !== 1'b1 || res_I !== 8'hA5) begin
            n_err++; $display("FAIL single_issue got=%b/%h exp=1/a5", res_valid, res_I);
        end
        repeat (3) tick();
        n_vec++;
        if (rsp_valid !== '0) begin
            n_err++; $display("FAIL single_early got=%b exp=0000", rsp_valid);
        end
        tick();
        n_vec++;
        if (rsp_valid !== 4'b0100 || rsp_data !== 8'h5A) begin
            n_err++; $display("FAIL single_rsp got=%b/%h exp=0100/5a", rsp_valid, rsp_data);
        end
        tick();
        n_vec++;
        if (rsp_valid !== '0 || rsp_data !== 8'h5A || inflight !== '0) begin
            n_err++;
            $display("FAIL single_after got=%b/%h/%0d exp=0000/5a/0", rsp_valid, rsp_data, inflight);
        end
    endtask

    task automatic test_round_robin();
        do_reset(1);
        req_valid = 4'hF;
        req_data  = {$urandom()};
        for (int k = 0; k < 14; k++) begin
            if (k == 8) req_valid = '0;
            tick();
            if (k < 8) begin
                n_vec++;
                if (act_ready !== N'(1 << (k % N))) begin
                    n_err++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, act_ready, N'(1 << (k % N)));
                end
                req_data[m_g*W +: W] = W'($urandom());
            end
            n_vec++;
            if (rsp_valid !== m_rsp_valid || (m_rsp_valid != 0 && rsp_data !== m_rsp_data)) begin
                n_err++;
                $display("FAIL rr_rsp cyc=%0d got=%b/%h exp=%b/%h", cyc, rsp_valid, rsp_data, m_rsp_valid, m_rsp_data);
            end
        end
    endtask

    task automatic test_pointer_skip();
        do_reset(1);
        req_valid = 4'b0001;
        req_data  = {$urandom()};
        tick();
        req_valid = 4'b1001;
        tick();
        n_vec++;
        if (act_ready !== 4'b1000) begin
            n_err++; $display("FAIL skip_grant3 got=%b exp=1000", act_ready);
        end
        tick();
        n_vec++;
        if (act_ready !== 4'b0001) begin
            n_err++; $display("FAIL skip_grant0 got=%b exp=0001", act_ready);
        end
        req_valid = '0;
        repeat (6) tick();
    endtask

    task automatic test_back_to_back();
        int pulses;
        int first;
        int last;
        int peak;
        do_reset(1);
        pulses = 0; first = -1; last = -1; peak = 0;
        req_valid = 4'b0001;
        req_data  = {$urandom()};
        for (int k = 0; k < 14; k++) begin
            if (k == 6) req_valid = '0;
            tick();
            if (int'(inflight) > peak) peak = int'(inflight);
            if (rsp_valid === 4'b0001) begin
                pulses++;
                if (first < 0) first = k;
                last = k;
            end
            n_vec++;
            if (rsp_valid !== m_rsp_valid || inflight !== CW'(m_inflight)) begin
                n_err++;
                $display("FAIL b2b_cycle k=%0d got=%b/%0d exp=%b/%0d", k, rsp_valid, inflight, m_rsp_valid, m_inflight);
            end
        end
        n_vec++;
        if (pulses != 6 || last - first != 5) begin
            n_err++; $display("FAIL b2b_pulses got=%0d span=%0d exp=6 span=5", pulses, last - first);
        end
        n_vec++;
        if (peak != LAT + 1) begin
            n_err++; $display("FAIL b2b_peak got=%0d exp=%0d", peak, LAT + 1);
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        do_reset(1);
        req_valid = 4'b0111;
        req_data  = {$urandom()};
        repeat (3) tick();
        req_valid = '0;
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        seen = 0;
        repeat (8) begin
            tick();
            if (rsp_valid !== '0) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++; $display("FAIL midflight_rsp got=%0d pulses exp=0", seen);
        end
        n_vec++;
        if (inflight !== '0) begin
            n_err++; $display("FAIL midflight_inflight got=%0d exp=0", inflight);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] pend_v;
        do_reset(1);
        pend_v = '0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend_v[i] && $urandom_range(0, 2) != 0) begin
                    pend_v[i] = 1'b1;
                    req_data[i*W +: W] = W'($urandom());
                end
            end
            req_valid = pend_v;
            RESET     = ($urandom_range(0, 59) == 0);
            tick();
            if (m_xfer) pend_v[m_g] = 1'b0;
            n_vec++;
            if (act_ready !== exp_ready) begin
                n_err++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, act_ready, exp_ready);
            end
            n_vec++;
            if (res_valid !== m_res_valid || res_I !== m_res_I) begin
                n_err++;
                $display("FAIL rnd_issue cyc=%0d got=%b/%h exp=%b/%h", cyc, res_valid, res_I, m_res_valid, m_res_I);
            end
            n_vec++;
            if (rsp_valid !== m_rsp_valid || rsp_data !== m_rsp_data) begin
                n_err++;
                $display("FAIL rnd_rsp cyc=%0d got=%b/%h exp=%b/%h", cyc, rsp_valid, rsp_data, m_rsp_valid, m_rsp_data);
            end
            n_vec++;
            if (inflight !== CW'(m_inflight)) begin
                n_err++; $display("FAIL rnd_inflight cyc=%0d got=%0d exp=%0d", cyc, inflight, m_inflight);
            end
        end
        RESET     = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        cyc         = 0;
        m_ptr       = 0;
        m_inflight  = 0;
        m_res_I     = '0;
        m_res_valid = 1'b0;
        m_rsp_valid = '0;
        m_rsp_data  = '0;
        RESET       = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        @(posedge CLK);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_skip();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
